// File: rtl/tx_fifo_pkg.sv
// Shared constants and pointer helpers for the parametrised TX FIFO.
package tx_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_ADDR_W     = $clog2(DEFAULT_DEPTH);

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                      wrap;
    logic [DEFAULT_ADDR_W-1:0] addr;
  } tx_ptr_t;

endpackage

// File: rtl/param_tx_fifo_if.sv
// Producer-side bus of the TX FIFO. With TX_FIFO_ERR_EN defined it also
// carries the sticky overflow/underflow flags.
interface param_tx_fifo_if #(
  parameter int DATA_WIDTH = tx_fifo_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = tx_fifo_pkg::DEFAULT_DEPTH
);
  localparam int CNT_W = tx_fifo_pkg::ptr_width(DEPTH);

  logic                  flush;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
`ifdef TX_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output flush, write_enable, write_data, read_enable,
    input  read_data, fifo_empty, fifo_full, almost_full, almost_empty, count
`ifdef TX_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  flush, write_enable, write_data, read_enable,
    output read_data, fifo_empty, fifo_full, almost_full, almost_empty, count
`ifdef TX_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/tx_fifo_ctrl.sv
// TX FIFO control: pointers, occupancy, flags and push/pop qualification.
// Sticky error flags are built only with TX_FIFO_ERR_EN defined.
module tx_fifo_ctrl
  import tx_fifo_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int PTR_W    = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic              push_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  count
`ifdef TX_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  typedef struct packed {
    logic              wrap;
    logic [ADDR_W-1:0] addr;
  } ptr_t;

  localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic pop_accept;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr.addr == rd_ptr.addr) && (wr_ptr.wrap != rd_ptr.wrap);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign wr_addr      = wr_ptr.addr;
  assign rd_addr      = rd_ptr.addr;

  // A pop in the same cycle frees the head slot, so a full FIFO still takes the push.
  assign pop_accept  = read_enable && !fifo_empty && !flush && !rst;
  assign push_accept = write_enable && (!fifo_full || read_enable) && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_accept) wr_ptr <= ptr_t'(wr_ptr + PTR_W'(1));
      if (pop_accept)  rd_ptr <= ptr_t'(rd_ptr + PTR_W'(1));
    end
  end

`ifdef TX_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && fifo_full && !read_enable) overflow  <= 1'b1;
      if (read_enable && fifo_empty)                 underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/param_tx_fifo.sv
// Parametrised single-clock transmit FIFO with show-ahead read data.
// Define TX_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module param_tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  parameter  int AF_LEVEL   = 6,
  parameter  int AE_LEVEL   = 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  param_tx_fifo_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push_accept;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;

  tx_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.flush),
    .write_enable (bus.write_enable),
    .read_enable  (bus.read_enable),
    .push_accept  (push_accept),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .fifo_empty   (bus.fifo_empty),
    .fifo_full    (bus.fifo_full),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty),
    .count        (bus.count)
`ifdef TX_FIFO_ERR_EN
    ,
    .overflow     (bus.overflow),
    .underflow    (bus.underflow)
`endif
  );

  // Storage is intentionally not reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_addr] <= bus.write_data;
  end

  assign bus.read_data = mem[rd_addr];

endmodule

// File: tb/tb_param_tx_fifo.sv
// Scoreboard bench for param_tx_fifo: queue-based reference model plus monitor.
module tb_param_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

  param_tx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_count;
  logic [3:0]    exp_flags;
  bit            mon_en = 1'b0;
`ifdef TX_FIFO_ERR_EN
  bit m_ovf = 1'b0, m_unf = 1'b0, exp_ovf, exp_unf;
`endif

  // Apply one cycle of stimulus; record expectations for the state seen before the edge.
  task automatic drive(input bit r, input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
    int sz;
    bit do_pop, do_push;
    @(posedge clk);
    #1;
    rst              = r;
    bus.flush        = fl;
    bus.write_enable = we;
    bus.write_data   = wd;
    bus.read_enable  = re;
    sz        = model_q.size();
    exp_count = sz;
    exp_flags = {sz == 0, sz == DEPTH, sz >= AF, sz <= AE};
`ifdef TX_FIFO_ERR_EN
    exp_ovf = m_ovf;
    exp_unf = m_unf;
`endif
    mon_en = 1'b1;
    if (r) begin
      model_q.delete();
`ifdef TX_FIFO_ERR_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
    end else begin
`ifdef TX_FIFO_ERR_EN
      if (we && sz == DEPTH && !re) m_ovf = 1'b1;
      if (re && sz == 0)            m_unf = 1'b1;
`endif
      if (fl) begin
        model_q.delete();
      end else begin
        do_pop  = re && (sz > 0);
        do_push = we && ((sz < DEPTH) || re);
        if (do_pop)  exp_q.push_back(model_q.pop_front());
        if (do_push) model_q.push_back(wd);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (mon_en) begin
      total++;
      if (bus.count !== exp_count[3:0]) begin
        bad++;
        $display("FAIL count: got %0d want %0d at %0t", bus.count, exp_count, $time);
      end
      total++;
      if ({bus.fifo_empty, bus.fifo_full, bus.almost_full, bus.almost_empty} !== exp_flags) begin
        bad++;
        $display("FAIL flags(empty,full,af,ae): got %b want %b at %0t",
                 {bus.fifo_empty, bus.fifo_full, bus.almost_full, bus.almost_empty}, exp_flags, $time);
      end
`ifdef TX_FIFO_ERR_EN
      total++;
      if ({bus.overflow, bus.underflow} !== {exp_ovf, exp_unf}) begin
        bad++;
        $display("FAIL errflags(ovf,unf): got %b want %b at %0t",
                 {bus.overflow, bus.underflow}, {exp_ovf, exp_unf}, $time);
      end
`endif
      if (!rst && !bus.flush && bus.read_enable && !bus.fifo_empty) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop: DUT popped 0x%02h but no pop expected at %0t", bus.read_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.read_data !== e) begin
            bad++;
            $display("FAIL read_data: got 0x%02h want 0x%02h at %0t", bus.read_data, e, $time);
          end
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.read_enable  = 1'b0;
    repeat (2) @(posedge clk);

    drive(0, 0, 0, 8'h00, 0);

    // fill to full, then one ignored push
    for (int i = 1; i <= 8; i++) drive(0, 0, 1, DW'(i), 0);
    drive(0, 0, 1, 8'hFF, 0);
    drive(0, 0, 0, 8'h00, 0);

    // drain in order, then one pop while empty
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 0);

    // pointer wrap past 8 and 16
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) drive(0, 0, 1, DW'($urandom), 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 8'h00, 1);
    end
    drive(0, 0, 0, 8'h00, 0);

    // simultaneous push+pop at full and at empty
    for (int i = 0; i < 8; i++) drive(0, 0, 1, DW'($urandom), 0);
    drive(0, 0, 1, 8'hAA, 1);
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 1, 8'h55, 1);
    drive(0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 1);

    // flush beats a concurrent push
    for (int i = 0; i < 4; i++) drive(0, 0, 1, DW'($urandom), 0);
    drive(0, 1, 1, 8'h77, 0);
    drive(0, 0, 0, 8'h00, 0);

    // reset beats flush and requests
    for (int i = 0; i < 3; i++) drive(0, 0, 1, DW'($urandom), 0);
    drive(1, 1, 1, 8'h33, 1);
    drive(0, 0, 0, 8'h00, 0);

    // randomised traffic
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 50));

    for (int i = 0; i < 10; i++) drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected pops never seen, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
